// File: rtl/yutorina_bus_arbiter.sv
// rtl/yutorina_bus_arbiter.sv - four-master rotating bus arbiter with active-low request/grant
// Optional tenure limit compiled in with YUTORINA_BUS_ARBITER_TIMEOUT_EN.
module yutorina_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       master0_request_,
    input  logic       master1_request_,
    input  logic       master2_request_,
    input  logic       master3_request_,
    output logic       master0_grant_,
    output logic       master1_grant_,
    output logic       master2_grant_,
    output logic       master3_grant_,
    output logic [1:0] owner,
    output logic       timeout_expired
);

    logic [3:0] w_req;
    logic [3:1] w_rot;
    logic       w_owner_req;
    logic       w_found;
    logic [1:0] w_next;
    logic       w_timeout;
    logic       w_move;

    logic [1:0] r_owner;
    logic [3:0] r_grant_n;
    logic       r_timeout;

    assign w_req = ~{master3_request_, master2_request_, master1_request_, master0_request_};
    assign w_owner_req = w_req[r_owner];

    // w_rot[k] is the request of master owner+k, so the search order is simply bit 1, 2, 3.
    always_comb begin
        w_rot = 3'b000;
        for (int k = 1; k < 4; k++) begin
            w_rot[k] = w_req[r_owner + 2'(k)];
        end
    end

    always_comb begin
        w_found = 1'b1;
        w_next  = r_owner;
        if (w_rot[1]) begin
            w_next = r_owner + 2'd1;
        end else if (w_rot[2]) begin
            w_next = r_owner + 2'd2;
        end else if (w_rot[3]) begin
            w_next = r_owner + 2'd3;
        end else begin
            w_found = 1'b0;
        end
    end

`ifdef YUTORINA_BUS_ARBITER_TIMEOUT_EN
    logic [7:0] r_tenure;

    assign w_timeout = w_owner_req && w_found && (r_tenure == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tenure <= 8'd0;
        end else if (w_move) begin
            r_tenure <= 8'd0;
        end else if (w_owner_req && w_found) begin
            r_tenure <= r_tenure + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_move = w_found && (!w_owner_req || w_timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner   <= 2'd0;
            r_grant_n <= 4'b1110;
            r_timeout <= 1'b0;
        end else begin
            if (w_move) begin
                r_owner   <= w_next;
                r_grant_n <= ~(4'b0001 << w_next);
            end
            r_timeout <= w_timeout;
        end
    end

    assign master0_grant_  = r_grant_n[0];
    assign master1_grant_  = r_grant_n[1];
    assign master2_grant_  = r_grant_n[2];
    assign master3_grant_  = r_grant_n[3];
    assign owner           = r_owner;
    assign timeout_expired = r_timeout;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb/tb_yutorina_bus_arbiter.sv - directed and randomized checks of yutorina_bus_arbiter against a rule model
module tb_yutorina_bus_arbiter;

    localparam int T = 4;
`ifdef YUTORINA_BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_n = 4'hF;
    logic       g0, g1, g2, g3;
    logic [1:0] owner;
    logic       to_exp;

    int checks   = 0;
    int failures = 0;

    int m_owner  = 0;
    int m_tenure = 0;
    bit m_to     = 1'b0;

    always #5 clk = ~clk;

    yutorina_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .reset            (rst),
        .master0_request_ (req_n[0]),
        .master1_request_ (req_n[1]),
        .master2_request_ (req_n[2]),
        .master3_request_ (req_n[3]),
        .master0_grant_   (g0),
        .master1_grant_   (g1),
        .master2_grant_   (g2),
        .master3_grant_   (g3),
        .owner            (owner),
        .timeout_expired  (to_exp)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [3:0] req;
        bit others;
        bit fire;
        int first;
        int j;
        if (rst) begin
            m_owner  = 0;
            m_tenure = 0;
            m_to     = 1'b0;
        end else begin
            req    = ~req_n;
            others = 1'b0;
            first  = -1;
            for (int k = 1; k < 4; k++) begin
                j = (m_owner + k) % 4;
                if (req[j]) begin
                    others = 1'b1;
                    if (first < 0) first = j;
                end
            end
            fire = TO_EN && req[m_owner] && others && (m_tenure == T - 1);
            if (req[m_owner] && !fire) begin
                m_to = 1'b0;
                if (others) m_tenure++;
            end else if (first >= 0) begin
                m_owner  = first;
                m_tenure = 0;
                m_to     = fire;
            end else begin
                m_to = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [3:0] g;
        logic [3:0] exp_g;
        @(posedge clk);
        model_update();
        #1;
        g     = {g3, g2, g1, g0};
        exp_g = ~(4'b0001 << m_owner);
        chk("model_owner", 8'(owner), 8'(m_owner));
        chk("model_grant", 8'(g), 8'(exp_g));
        chk("model_timeout", 8'(to_exp), 8'(m_to));
        chk("one_grant_low", 8'($countones(~g)), 8'd1);
    endtask

    initial begin
        // Reset, then park on master0 with nobody requesting.
        rst = 1'b1; req_n = 4'hF;
        step(); step();
        rst = 1'b0;
        chk("reset_owner", 8'(owner), 8'd0);
        chk("reset_grant", 8'({g3, g2, g1, g0}), 8'h0E);
        chk("reset_timeout", 8'(to_exp), 8'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("parked_owner", 8'(owner), 8'd0);
            chk("parked_grant", 8'({g3, g2, g1, g0}), 8'h0E);
        end

        // Master0 holds, masters 1 and 3 wait; handover goes 0 -> 1 -> 3.
        req_n = 4'b1110; step();
        req_n = 4'b0100; step(); step();
        chk("hold_owner0", 8'(owner), 8'd0);
        req_n = 4'b0101; step();
        chk("handover_to1", 8'(owner), 8'd1);
        req_n = 4'b0111; step();
        chk("handover_to3", 8'(owner), 8'd3);
        req_n = 4'b1111; step();
        chk("park_on3", 8'(owner), 8'd3);

        // Owner 2 with everyone requesting; rotation goes 3, 0, 1.
        req_n = 4'b1011; step();
        chk("get_owner2", 8'(owner), 8'd2);
        req_n = 4'b0000; step();
        chk("all_req_hold2", 8'(owner), 8'd2);
        req_n = 4'b0100; step();
        chk("rot_to3", 8'(owner), 8'd3);
        req_n = 4'b1100; step();
        chk("rot_to0", 8'(owner), 8'd0);
        req_n = 4'b1101; step();
        chk("rot_to1", 8'(owner), 8'd1);

        // Master1 holds while master2 waits continuously.
        req_n = 4'b1001;
`ifdef YUTORINA_BUS_ARBITER_TIMEOUT_EN
        for (int i = 1; i <= T; i++) begin
            step();
            if (i < T) begin
                chk("tenure_hold1", 8'(owner), 8'd1);
                chk("tenure_no_pulse", 8'(to_exp), 8'd0);
            end else begin
                chk("timeout_to2", 8'(owner), 8'd2);
                chk("timeout_pulse", 8'(to_exp), 8'd1);
            end
        end
        step();
        chk("timeout_pulse_end", 8'(to_exp), 8'd0);
        chk("timeout_new_owner_holds", 8'(owner), 8'd2);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            chk("no_timeout_hold1", 8'(owner), 8'd1);
            chk("no_timeout_pulse", 8'(to_exp), 8'd0);
        end
`endif

        // Reset pulse while master3 owns and keeps requesting.
        req_n = 4'b0111; step(); step();
        chk("owner3_before_reset", 8'(owner), 8'd3);
        rst = 1'b1; step();
        chk("midreset_owner", 8'(owner), 8'd0);
        chk("midreset_grant0", 8'(g0), 8'd0);
        rst = 1'b0; step();
        chk("after_reset_to3", 8'(owner), 8'd3);

        // Randomized requests with occasional resets, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) req_n = 4'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
